// File: rtl/gpio_input_conditioner_pkg.sv
// Shared GPIO input constants and helpers.
// Board tops and the localbus GPIO slave take their defaults from here so that
// every user of the conditioner agrees on pin count and debounce timing.
package gpio_input_conditioner_pkg;

  localparam int GPIO_IN_WIDTH        = 13;
  localparam int GPIO_SYNC_STAGES     = 2;
  localparam int GPIO_DEBOUNCE_CYCLES = 100000;  // 1 ms at 100 MHz
  localparam int GPIO_CNT_W           = 17;

  // Terminal count of the debounce counter: a new level is accepted when the
  // counter sits here and the synchronized pin still disagrees with the level.
  function automatic int debounce_tc(input int cycles);
    return cycles - 1;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// One pin of the GPIO input conditioner.
// Synchronizes the raw pin, debounces it with a saturating-free counter that
// restarts whenever the pin returns to the accepted level, and produces
// registered one-cycle rise/fall pulses from the accepted level.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   pin_in     raw asynchronous pin level
//   level_out  debounced level
//   rise_pulse one-cycle pulse, cycle after level_out goes 0->1
//   fall_pulse one-cycle pulse, cycle after level_out goes 1->0
module gpio_debounce_bit
  import gpio_input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
  parameter int CNT_W           = GPIO_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_in,
  output logic level_out,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(debounce_tc(DEBOUNCE_CYCLES));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CNT_W-1:0]       cnt;
  logic                   level_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      cnt        <= '0;
      level_out  <= 1'b0;
      level_d    <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};

      // Any agreement with the accepted level discards the partial count, so
      // only an unbroken run of DEBOUNCE_CYCLES disagreeing samples is accepted.
      if (s == level_out) begin
        cnt <= '0;
      end else if (cnt == CNT_TC) begin
        level_out <= s;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // Pulses come from the accepted level and its one-cycle-old copy, so
      // they land in the cycle after level_out changes.
      level_d    <= level_out;
      rise_pulse <= level_out & ~level_d;
      fall_pulse <= ~level_out & level_d;
    end
  end

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: per-pin synchronize/debounce/edge-detect followed by
// sticky, maskable event flags with write-1-to-clear and a single irq.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   pin_in       raw pin levels
//   rise_en      per-pin enable for rising-edge events
//   fall_en      per-pin enable for falling-edge events
//   evt_clr      write-1-to-clear strobe for evt_pending
//   level_out    debounced pin levels
//   rise_pulse   one-cycle rising-edge pulses
//   fall_pulse   one-cycle falling-edge pulses
//   evt_pending  sticky event flags
//   irq          registered OR of evt_pending
module gpio_input_conditioner
  import gpio_input_conditioner_pkg::*;
#(
  parameter int WIDTH           = GPIO_IN_WIDTH,
  parameter int SYNC_STAGES     = GPIO_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES,
  parameter int CNT_W           = GPIO_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] rise_en,
  input  logic [WIDTH-1:0] fall_en,
  input  logic [WIDTH-1:0] evt_clr,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic [WIDTH-1:0] evt_pending,
  output logic             irq
);

  logic [WIDTH-1:0] evt_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    gpio_debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_bit (
      .clk        (clk),
      .rst        (rst),
      .pin_in     (pin_in[i]),
      .level_out  (level_out[i]),
      .rise_pulse (rise_pulse[i]),
      .fall_pulse (fall_pulse[i])
    );
  end

  assign evt_set = (rise_pulse & rise_en) | (fall_pulse & fall_en);

  // Set beats clear so an event arriving alongside a clear write is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_pending <= '0;
      irq         <= 1'b0;
    end else begin
      evt_pending <= evt_set | (evt_pending & ~evt_clr);
      irq         <= |evt_pending;
    end
  end

endmodule

// File: tb/tb_gpio_input_conditioner.sv
module tb_gpio_input_conditioner;

  localparam int W = 13;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pin_in, rise_en, fall_en, evt_clr;
  logic [W-1:0] level_out, rise_pulse, fall_pulse, evt_pending;
  logic         irq;

  int checks   = 0;
  int failures = 0;

  gpio_input_conditioner #(
    .WIDTH           (W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pin_in      (pin_in),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .evt_clr     (evt_clr),
    .level_out   (level_out),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .evt_pending (evt_pending),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pin, ren, fen, clr;
    logic [W-1:0] lvl, rise, fall, pend;
    logic         irq;
  } vec_t;

  vec_t tbl[$];

  function void add(input logic [W-1:0] pin, ren, fen, clr,
                    input logic [W-1:0] lvl, rise, fall, pend,
                    input logic         irq_e);
    vec_t v;
    v.pin = pin; v.ren = ren; v.fen = fen; v.clr = clr;
    v.lvl = lvl; v.rise = rise; v.fall = fall; v.pend = pend; v.irq = irq_e;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [W-1:0] lvl, rise, fall, pend,
                         input logic irq_e);
    chk({name, " level"}, 32'(level_out), 32'(lvl));
    chk({name, " rise"},  32'(rise_pulse), 32'(rise));
    chk({name, " fall"},  32'(fall_pulse), 32'(fall));
    chk({name, " pend"},  32'(evt_pending), 32'(pend));
    chk({name, " irq"},   32'(irq), 32'(irq_e));
  endtask

  // One clock edge, then settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pin_in = '0; rise_en = '0; fall_en = '0; evt_clr = '0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pin_in = '0; rise_en = '0; fall_en = '0; evt_clr = '0;

    // Reset and idle
    repeat (3) step();
    chk_all("reset", '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (k % 5 == 4) chk_all($sformatf("idle%0d", k), '0, '0, '0, '0, 1'b0);
    end

    // Clean rise on pin 3, clear, then an unmasked-for-rise-only fall
    do_reset();
    for (int k = 1; k <= 5; k++) add(13'h0008, 13'h0008, 0, 0, 0, 0, 0, 0, 0);
    add(13'h0008, 13'h0008, 0, 0,      13'h0008, 0, 0, 0, 0);             // 6
    add(13'h0008, 13'h0008, 0, 0,      13'h0008, 13'h0008, 0, 0, 0);      // 7
    add(13'h0008, 13'h0008, 0, 0,      13'h0008, 0, 0, 13'h0008, 0);      // 8
    add(13'h0008, 13'h0008, 0, 0,      13'h0008, 0, 0, 13'h0008, 1);      // 9
    add(13'h0008, 13'h0008, 0, 13'h0008, 13'h0008, 0, 0, 0, 1);           // 10
    add(13'h0008, 13'h0008, 0, 0,      13'h0008, 0, 0, 0, 0);             // 11
    for (int k = 12; k <= 16; k++) add(0, 13'h0008, 0, 0, 13'h0008, 0, 0, 0, 0);
    add(0, 13'h0008, 0, 0, 0, 0, 0, 0, 0);                                // 17
    add(0, 13'h0008, 0, 0, 0, 0, 13'h0008, 0, 0);                         // 18
    add(0, 13'h0008, 0, 0, 0, 0, 0, 0, 0);                                // 19
    foreach (tbl[i]) begin
      pin_in = tbl[i].pin; rise_en = tbl[i].ren; fall_en = tbl[i].fen; evt_clr = tbl[i].clr;
      step();
      chk_all($sformatf("vec%0d", i + 1), tbl[i].lvl, tbl[i].rise, tbl[i].fall,
              tbl[i].pend, tbl[i].irq);
    end
    evt_clr = '0;

    // Glitch: 3-cycle pulse never accepted
    do_reset();
    rise_en = 13'h0001; fall_en = 13'h0001;
    for (int k = 1; k <= 15; k++) begin
      pin_in = (k <= 3) ? 13'h0001 : 13'h0000;
      step();
      chk($sformatf("glitch3 level k%0d", k), 32'(level_out[0]), 32'd0);
      chk($sformatf("glitch3 rise k%0d", k), 32'(rise_pulse[0]), 32'd0);
      chk($sformatf("glitch3 pend k%0d", k), 32'(evt_pending[0]), 32'd0);
    end

    // 4-cycle pulse: accepted at edge 6, released at edge 10
    do_reset();
    rise_en = 13'h0001;
    for (int k = 1; k <= 14; k++) begin
      pin_in = (k <= 4) ? 13'h0001 : 13'h0000;
      step();
      chk($sformatf("pulse4 level k%0d", k), 32'(level_out[0]), 32'((k >= 6 && k <= 9) ? 1 : 0));
      chk($sformatf("pulse4 rise k%0d", k), 32'(rise_pulse[0]), 32'((k == 7) ? 1 : 0));
      chk($sformatf("pulse4 fall k%0d", k), 32'(fall_pulse[0]), 32'((k == 11) ? 1 : 0));
    end
    chk("pulse4 pend", 32'(evt_pending), 32'h0001);

    // Set/clear collision on pin 5
    do_reset();
    rise_en = 13'h0020; fall_en = 13'h0020;
    pin_in = 13'h0020;
    repeat (9) step();
    chk("coll pend set", 32'(evt_pending), 32'h0020);
    pin_in = 13'h0000;
    repeat (7) step();                                  // edges 10..16
    chk("coll fall pulse", 32'(fall_pulse), 32'h0020);
    evt_clr = 13'h0020;
    step();                                             // edge 17: set and clear together
    chk("coll pend kept", 32'(evt_pending), 32'h0020);
    step();                                             // edge 18: clear alone
    evt_clr = '0;
    chk("clr pend", 32'(evt_pending), 32'h0000);
    chk("clr irq lag", 32'(irq), 32'd1);
    step();
    chk("clr irq", 32'(irq), 32'd0);

    // Masked pin 7
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      pin_in = (k < 10) ? 13'h0080 : 13'h0000;
      step();
      chk_all($sformatf("mask k%0d", k),
              (k >= 6 && k < 15) ? 13'h0080 : 13'h0000,
              (k == 7) ? 13'h0080 : 13'h0000,
              (k == 16) ? 13'h0080 : 13'h0000,
              13'h0000, 1'b0);
    end

    // Reset mid-debounce on pin 2
    do_reset();
    rise_en = 13'h0004;
    pin_in  = 13'h0004;
    repeat (4) step();
    chk("midrst pre level", 32'(level_out), 32'h0);
    rst = 1'b1;
    repeat (2) step();
    chk_all("midrst in reset", '0, '0, '0, '0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("midrst level k%0d", k), 32'(level_out), 32'((k >= 6) ? 13'h0004 : 13'h0));
      chk($sformatf("midrst rise k%0d", k), 32'(rise_pulse), 32'((k == 7) ? 13'h0004 : 13'h0));
    end
    chk("midrst pend", 32'(evt_pending), 32'h0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
